// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl -- multi-cycle load/store unit.
//
// Accepts one LOAD/STORE at a time from execute, translates it into a
// word-organised req/gnt/rvalid memory transaction with byte enables and
// lane-replicated store data, and returns a one-cycle completion pulse with
// sign/zero-extended load data. The word at OUTPORT_ADDR is served locally
// by an output port register instead of memory.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake from execute
//   req_is_store             1 = STORE, 0 = LOAD
//   req_funct3               width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr, req_wdata      effective address and store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     extended load data / error flag
//   mem_req ... mem_wdata    memory request (held until mem_gnt)
//   mem_gnt, mem_rvalid      memory accept / read data valid
//   mem_rdata                memory read word
//   outport                  memory-mapped output port register
module lsu_mem_ctrl #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] OUTPORT_ADDR = 16'hfffc
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           outport
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_RESP} state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_err;
  logic        w_is_outport;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_outport_merged;
  logic        w_unused;

  // Address bits above ADDR_WIDTH do not take part in decoding.
  assign w_unused = ^req_addr[31:ADDR_WIDTH];

  // Unsigned widths are only meaningful for loads.
  assign w_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111) || (req_is_store && req_funct3[2]);
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  assign w_err      = w_illegal || w_misalign;

  assign w_is_outport = (req_addr[ADDR_WIDTH-1:2] == OUTPORT_ADDR[ADDR_WIDTH-1:2]);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  // Byte-lane merge of a store into the output port register.
  for (genvar gi = 0; gi < 4; gi++) begin : g_outport_lane
    assign w_outport_merged[8*gi +: 8] = w_be[gi] ? w_wdata[8*gi +: 8] : outport[8*gi +: 8];
  end

  // Select the addressed lane of a read word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  extract_load = {{24{sh[7]}}, sh[7:0]};
      3'b100:  extract_load = {24'h0, sh[7:0]};
      3'b001:  extract_load = {{16{sh[15]}}, sh[15:0]};
      3'b101:  extract_load = {16'h0, sh[15:0]};
      default: extract_load = word;
    endcase
  endfunction

  // Ready only in IDLE, and never in the cycle reset is asserted.
  assign req_ready = (r_state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_funct3   <= 3'b000;
      r_off      <= 2'b00;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0;
      outport    <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            if (w_err) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (w_is_outport) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              if (req_is_store) begin
                outport    <= w_outport_merged;
                resp_rdata <= 32'h0;
              end else begin
                resp_rdata <= extract_load(outport, req_funct3, req_addr[1:0]);
              end
            end else begin
              r_state   <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_is_store;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'h0;
            end else begin
              r_state <= S_WAIT_R;
            end
          end
        end
        S_WAIT_R: begin
          if (mem_rvalid) begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extract_load(mem_rdata, r_funct3, r_off);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Multi-cycle load/store unit sitting directly downstream of instruction decode/execute. It consumes LOAD/STORE operations identified by opcode, with the funct3 width codes BYTE/HALF/WORD/BYTE_U/HALF_U and the effective address from the ALU. It drives a word-organised data memory through a req/gnt/rvalid handshake. It also implements the memory-mapped output port at OUTPORT_ADDR (16'hfffc). Load results go to the regfile write-back mux (FROM_MEM path).

Parameters:
ADDR_WIDTH, 16, width of memory address compared and driven to memory (low bits of req_addr)
OUTPORT_ADDR, 16'hfffc, word address of output port register

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  load/store request from execute
req_ready  out  1  unit accepts request this cycle
req_is_store  in  1  1=STORE opcode, 0=LOAD opcode
req_funct3  in  3  width code (BYTE/HALF/WORD/BYTE_U/HALF_U)
req_addr  in  32  effective address (rs1+imm)
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse (loads and stores)
resp_rdata  out  32  extended load data, 0 for stores/errors
resp_err  out  1  misaligned or illegal funct3, qualified by resp_valid
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  write enable
mem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-aligned store data
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
outport  out  32  output port register

Behaviour:
- Reset: state IDLE; req_ready=0 during the rst cycle, 1 afterwards in IDLE. resp_valid, resp_err, mem_req, mem_we = 0. mem_addr, mem_be, mem_wdata, resp_rdata, outport = 0.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE: req_ready=1. When req_valid is high, latch all request fields.
  - Error (illegal funct3 011/110/111, store with 100/101, or misaligned) -> RESP with err=1. No memory access.
  - Store whose word address equals OUTPORT_ADDR -> update outport lanes selected by be -> RESP. No memory access.
  - Load whose word address equals OUTPORT_ADDR -> read outport instead of memory -> RESP.
  - Otherwise -> REQ.
- Alignment: HALF/HALF_U misaligned if addr[0]=1. WORD misaligned if addr[1:0]!=0. BYTE is never misaligned.
- Byte enables:
  - BYTE: be = 4'b0001<<addr[1:0]; wdata = byte replicated into all 4 lanes.
  - HALF: be = addr[1] ? 1100 : 0011; wdata = halfword replicated into both halves.
  - WORD: be = 1111.
- REQ: mem_req=1, with mem_we/addr/be/wdata stable until the cycle mem_gnt=1. On gnt, a store goes to RESP and a load goes to WAIT_R. mem_req drops the cycle after gnt.
- WAIT_R: on mem_rvalid, extract the lane by addr[1:0]. BYTE/HALF are sign-extended; BYTE_U/HALF_U are zero-extended. Then go to RESP. mem_rvalid in any other state is ignored.
- RESP: resp_valid=1 for exactly one cycle with rdata/err; req_ready=0; next state IDLE.
- Latency with zero-wait memory:
  - store: accept at edge 0, gnt during cycle 1, resp_valid in cycle 2.
  - load: rvalid in cycle 2, resp_valid in cycle 3.
  - error/outport: resp_valid in cycle 1.
- One outstanding request maximum. No back-to-back acceptance while not IDLE.
- Reset mid-operation: FSM returns to IDLE and mem_req drops after the rst edge. Outport is cleared. A pending rvalid arriving later is ignored.
- resp_rdata holds its value until the next RESP; it is 0 for stores and errors.

Test Plan:
- Store WORD 0xDEADBEEF to addr 0x0100, gnt after 2 wait cycles -> mem_req held 3 cycles, mem_addr=0x0100, be=1111, wdata=0xDEADBEEF, one resp_valid with err=0.
- Store BYTE 0x000000A5 to 0x0103 -> be=1000, wdata=0xA5A5A5A5. Then load BYTE from 0x0103 with rdata=0xA5000000 -> resp_rdata=0xFFFFFFA5; BYTE_U gives 0x000000A5.
- Load HALF_U from 0x0202 with rdata=0x8001xxxx -> resp_rdata=0x00008001; HALF gives 0xFFFF8001.
- Load WORD from 0x0102 -> resp_valid in cycle 1, resp_err=1, mem_req never asserted. Store with funct3=3'b100 -> resp_err=1.
- Store WORD 0x12345678 to 0xFFFC -> outport=0x12345678, no mem_req. Store BYTE 0xFF to 0xFFFD -> outport=0x1234FF78. Load WORD from 0xFFFC -> 0x1234FF78.
- Assert rst during WAIT_R of a load, then pulse mem_rvalid -> no resp_valid, outport=0, req_ready=1 the cycle after rst deasserts.
